// File: rtl/ram_fifo_ctrl.sv
// FIFO controller sequencing a 16x8 sync dual-port RAM: pointers, count, flags.
// Define RAM_FIFO_CTRL_ERR_EN to build sticky overflow/underflow error flags.
module ram_fifo_ctrl #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  output logic              we,
  output logic              re,
  output logic [ADDR_W-1:0] w_add,
  output logic [ADDR_W-1:0] r_add,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  input  logic              clr_err,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Strobes are suppressed during reset even though flags already read idle
  assign we    = push & ~full & ~reset;
  assign re    = pop & ~empty & ~reset;
  assign w_add = wr_ptr;
  assign r_add = rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= re;
      if (we)
        wr_ptr <= wr_ptr + 1'b1;
      if (re)
        rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        (we & ~re): count <= count + 1'b1;
        (re & ~we): count <= count - 1'b1;
        default:    count <= count;
      endcase
    end
  end

`ifdef RAM_FIFO_CTRL_ERR_EN
  // Set takes priority over clear when both land on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full)
        overflow <= 1'b1;
      else if (clr_err)
        overflow <= 1'b0;
      if (pop & empty)
        underflow <= 1'b1;
      else if (clr_err)
        underflow <= 1'b0;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_err;
  assign overflow   = 1'b0;
  assign underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: queue-free occupancy model
// plus directed sequences with literal expectations.
module tb_ram_fifo_ctrl;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic       pop;
  logic       clr_err;
  logic       we;
  logic       re;
  logic [3:0] w_add;
  logic [3:0] r_add;
  logic       rd_valid;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int vectors = 0;
  int errors  = 0;
  bit err_en;

  ram_fifo_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .we           (we),
    .re           (re),
    .w_add        (w_add),
    .r_add        (r_add),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .clr_err      (clr_err),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Model: occupancy and pointer positions as plain integers
  int m_cnt;
  int m_wp;
  int m_rp;
  bit m_rv;
  bit m_ov;
  bit m_un;

  function automatic bit acc_w();
    return push && m_cnt < DEPTH;
  endfunction

  function automatic bit acc_r();
    return pop && m_cnt > 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0;
      m_wp  <= 0;
      m_rp  <= 0;
      m_rv  <= 0;
      m_ov  <= 0;
      m_un  <= 0;
    end else begin
      m_cnt <= m_cnt + int'(acc_w()) - int'(acc_r());
      m_wp  <= (m_wp + int'(acc_w())) % DEPTH;
      m_rp  <= (m_rp + int'(acc_r())) % DEPTH;
      m_rv  <= acc_r();
      if (err_en) begin
        m_ov <= (push && m_cnt == DEPTH) ? 1'b1 : (clr_err ? 1'b0 : m_ov);
        m_un <= (pop && m_cnt == 0) ? 1'b1 : (clr_err ? 1'b0 : m_un);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("we", we, int'(acc_w() && !reset));
    check("re", re, int'(acc_r() && !reset));
    check("w_add", w_add, m_wp);
    check("r_add", r_add, m_rp);
    check("rd_valid", rd_valid, m_rv);
    check("count", count, m_cnt);
    check("full", full, int'(m_cnt == DEPTH));
    check("empty", empty, int'(m_cnt == 0));
    check("almost_full", almost_full, int'(m_cnt >= 14));
    check("almost_empty", almost_empty, int'(m_cnt <= 2));
    check("overflow", overflow, m_ov);
    check("underflow", underflow, m_un);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic ops(input bit p, input bit q, input int n);
    push = p;
    pop  = q;
    repeat (n) tick();
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
`ifdef RAM_FIFO_CTRL_ERR_EN
    err_en = 1'b1;
`else
    err_en = 1'b0;
`endif
    reset   = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
    #1;
    do_reset();
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_rv", rd_valid, 0);

    // Fill with 16 pushes
    push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("fill_we", we, 1);
      check("fill_wadd", w_add, i);
      tick();
      if (i == 12) check("af_at13", almost_full, 0);
      if (i == 13) check("af_at14", almost_full, 1);
    end
    check("full_cnt", count, 16);
    check("full_flag", full, 1);
    check("full_af", almost_full, 1);
    #1;
    check("ovf_we", we, 0);
    tick();
    push = 1'b0;
    check("ovf_wadd", w_add, 0);
    check("ovf_flag", overflow, int'(err_en));

    // Drain with 16 pops
    pop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("drain_re", re, 1);
      check("drain_radd", r_add, i);
      tick();
      check("drain_rv", rd_valid, 1);
    end
    #1;
    check("unf_re", re, 0);
    tick();
    pop = 1'b0;
    check("unf_rv", rd_valid, 0);
    check("drain_cnt", count, 0);
    check("drain_empty", empty, 1);
    check("unf_flag", underflow, int'(err_en));
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_ovf", overflow, 0);
    check("clr_unf", underflow, 0);

    // Wrap-around
    do_reset();
    ops(1, 0, 10);
    ops(0, 1, 10);
    push = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("wrap_wadd", w_add, (10 + i) % 16);
      tick();
    end
    push = 1'b0;
    check("wrap_cnt", count, 10);
    check("wrap_radd", r_add, 10);

    // Simultaneous push+pop at 5, 0 and 16
    ops(0, 1, 5);
    check("sim5_pre", count, 5);
    ops(1, 1, 1);
    check("sim5_cnt", count, 5);
    check("sim5_wadd", w_add, 5);
    check("sim5_radd", r_add, 0);
    ops(0, 1, 5);
    push = 1'b1;
    pop  = 1'b1;
    #1;
    check("sim0_re", re, 0);
    tick();
    ops(0, 0, 0);
    check("sim0_cnt", count, 1);
    ops(1, 0, 15);
    push = 1'b1;
    pop  = 1'b1;
    #1;
    check("sim16_we", we, 0);
    tick();
    ops(0, 0, 0);
    check("sim16_cnt", count, 15);

    // Asynchronous reset with a read in flight at count 7
    do_reset();
    ops(1, 0, 8);
    ops(0, 1, 1);
    check("inflight_rv", rd_valid, 1);
    check("inflight_cnt", count, 7);
    #2;
    reset = 1'b1;
    #1;
    check("arst_cnt", count, 0);
    check("arst_empty", empty, 1);
    check("arst_rv", rd_valid, 0);
    tick();
    reset = 1'b0;
    push  = 1'b1;
    #1;
    check("post_wadd", w_add, 0);
    check("post_we", we, 1);
    tick();
    push = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
